dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 26 ++
 rtl/dmem_lane_align.sv | 68 ++++++
 rtl/dmem_responder.sv | 144 ++++++++++++++
 tb/tb_dmem_responder.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared data-memory encodings: access sizes and responder FSM states.
// Also consumed by the processor control decoder.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } dmem_state_e;

  // Size 2'b11 behaves as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = off[0];
      default: mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane logic: byte enables, big-endian store merge, load extract/extend.
// Offset 0 is the most significant byte of the 32-bit word.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter bit CHECK_ALIGN = 1'b0
) (
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] word_i,
  output logic [31:0] merged_o,
  output logic [31:0] load_o,
  output logic        err_o
);

  logic [1:0]  half_off;
  logic [3:0]  be;
  logic [4:0]  shamt;
  logic [31:0] lane_data;
  logic [31:0] rd_shift;

  assign half_off = {offset_i[1], 1'b0};

  always_comb begin
    be    = 4'b1111;
    shamt = 5'd0;
    case (size_i)
      SZ_BYTE: begin
        be    = 4'b1000 >> offset_i;
        shamt = {2'd3 - offset_i, 3'b000};
      end
      SZ_HALF: begin
        be    = 4'b1100 >> half_off;
        shamt = {2'd2 - half_off, 3'b000};
      end
      default: begin
        be    = 4'b1111;
        shamt = 5'd0;
      end
    endcase
  end

  // Same shift moves store data up into its lanes and load data down to bit 0.
  assign lane_data = wdata_i << shamt;
  assign rd_shift  = word_i >> shamt;

  always_comb begin
    merged_o = word_i;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged_o[8*i +: 8] = lane_data[8*i +: 8];
    end
  end

  always_comb begin
    case (size_i)
      SZ_BYTE: load_o = sign_i ? {{24{rd_shift[7]}}, rd_shift[7:0]}
                               : {24'h0, rd_shift[7:0]};
      SZ_HALF: load_o = sign_i ? {{16{rd_shift[15]}}, rd_shift[15:0]}
                               : {16'h0, rd_shift[15:0]};
      default: load_o = rd_shift;
    endcase
  end

  assign err_o = CHECK_ALIGN && is_misaligned(size_i, offset_i);

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed wait states.
// Optional alignment checking is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2,
  parameter     INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  dmem_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] addr_q, wdata_q;
  logic        we_q, sign_q;
  logic [1:0]  size_q;

  logic [31:0] cur_addr, cur_wdata;
  logic        cur_we, cur_sign;
  logic [1:0]  cur_size;

  logic [AW-1:0] idx;
  logic [31:0]   word_rd, merged, load_word;
  logic          align_err, accept, enter_resp, mem_we;

  logic [31:0] mem_q [DEPTH_WORDS];

  assign accept = req_valid && (state_q == ST_IDLE);

  // With zero wait states the access completes on the accept edge, so use live inputs in IDLE.
  assign cur_addr  = (state_q == ST_IDLE) ? req_addr  : addr_q;
  assign cur_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;
  assign cur_we    = (state_q == ST_IDLE) ? req_we    : we_q;
  assign cur_size  = (state_q == ST_IDLE) ? req_size  : size_q;
  assign cur_sign  = (state_q == ST_IDLE) ? req_sign  : sign_q;

  assign idx     = AW'(cur_addr >> 2);
  assign word_rd = mem_q[idx];

  dmem_lane_align #(
    .CHECK_ALIGN (ALIGN_CHECK)
  ) u_lane (
    .size_i   (cur_size),
    .sign_i   (cur_sign),
    .offset_i (cur_addr[1:0]),
    .wdata_i  (cur_wdata),
    .word_i   (word_rd),
    .merged_o (merged),
    .load_o   (load_word),
    .err_o    (align_err)
  );

  assign enter_resp = (state_q != ST_RESP) && (state_d == ST_RESP);
  assign mem_we     = enter_resp && cur_we && !align_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (enter_resp) begin
        rdata_q <= (cur_we || align_err) ? 32'h0 : load_word;
        err_q   <= align_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      we_q    <= req_we;
      size_q  <= req_size;
      sign_q  <= req_sign;
    end
  end

  // Storage is never reset; a reset before commit simply drops the pending store.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx] <= merged;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (WAIT_STATES == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == ST_IDLE);
    rsp_valid = (state_q == ST_RESP);
    rsp_rdata = rdata_q;
    rsp_err   = err_q;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a byte-array memory model.
module tb_dmem_responder;

  localparam int DEPTH = 64;
  localparam int WS    = 2;
  localparam int NB    = 4 * DEPTH;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_sign = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .WAIT_STATES (WS),
    .INIT_FILE   ("")
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_we    (req_we),
    .req_size  (req_size),
    .req_sign  (req_sign),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          rdy_mode = 0;
  int          acc_cyc  = 0;
  int          rise_cyc = 0;
  bit          seen     = 1'b0;
  logic [31:0] last_rdata = 32'h0;
  logic        last_err   = 1'b0;
  logic [7:0]  mb [NB];
  exp_t        exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour: big-endian byte array, address wraps modulo the storage size.
  task automatic model_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [1:0] size, input logic sign,
                              output logic [31:0] rdata, output logic err);
    int sz, a, base;
    logic [31:0] v;
    sz    = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    a     = int'(addr % NB);
    base  = a - (a % sz);
    v     = 32'h0;
    err   = 1'b0;
    rdata = 32'h0;
`ifdef DMEM_ALIGN_CHECK_EN
    if ((a % sz) != 0) begin
      err = 1'b1;
      return;
    end
`endif
    if (we) begin
      for (int k = 0; k < sz; k++) mb[base + k] = 8'(wdata >> (8 * (sz - 1 - k)));
      return;
    end
    for (int k = 0; k < sz; k++) v = (v << 8) | {24'h0, mb[base + k]};
    if (sign && sz < 4 && v[8*sz-1]) v = v | ~((32'd1 << (8 * sz)) - 32'd1);
    rdata = v;
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic sign, input bit commit = 1'b1);
    bit   got;
    exp_t e;
    @(posedge clk);
    #1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_size  = size;
    req_sign  = sign;
    req_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    acc_cyc = cyc;
    @(posedge clk);
    if (commit) begin
      model_access(we, addr, wdata, size, sign, e.rdata, e.err);
      e.due = acc_cyc + 1 + WS;
      exp_q.push_back(e);
    end
    #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_we    = 1'($urandom_range(0, 1));
    req_size  = 2'($urandom_range(0, 3));
    req_sign  = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0) return;
    end
    chk("response_timeout", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [1:0] size, input logic sign);
    issue(we, addr, wdata, size, sign, 1'b1);
    wait_done();
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       rsp_ready = 1'b0;
        2:       rsp_ready = 1'b1;
        default: rsp_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Every cycle outside reset: idle/busy handshake, latency, and held response contents.
  always @(negedge clk) begin
    if (!reset) begin
      if (exp_q.size() == 0) begin
        chk("idle_req_ready", {31'h0, req_ready}, 32'd1);
        chk("idle_rsp_valid", {31'h0, rsp_valid}, 32'd0);
      end else begin
        chk("busy_req_ready", {31'h0, req_ready}, 32'd0);
        if (cyc < exp_q[0].due) begin
          chk("early_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        end else begin
          chk("rsp_valid", {31'h0, rsp_valid}, 32'd1);
          chk("rsp_rdata", rsp_rdata, exp_q[0].rdata);
          chk("rsp_err", {31'h0, rsp_err}, {31'h0, exp_q[0].err});
          if (rsp_valid && !seen) begin
            seen     = 1'b1;
            rise_cyc = cyc;
          end
          if (rsp_valid && rsp_ready) begin
            last_rdata = rsp_rdata;
            last_err   = rsp_err;
            seen       = 1'b0;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] old_word;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_req_ready", {31'h0, req_ready}, 32'd1);
    chk("reset_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", {31'h0, rsp_err}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    for (int w = 0; w < DEPTH; w++) xfer(1'b1, 32'(w * 4), $urandom, 2'b10, 1'b0);

    xfer(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0);
    chk("store_latency", 32'(rise_cyc - acc_cyc), 32'd3);
    chk("store_rdata", last_rdata, 32'h0);
    chk("store_err", {31'h0, last_err}, 32'd0);
    xfer(1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
    chk("load_word", last_rdata, 32'hDEADBEEF);
    chk("load_latency", 32'(rise_cyc - acc_cyc), 32'd3);
    xfer(1'b0, 32'h11, 32'h0, 2'b00, 1'b1);
    chk("load_byte_signed", last_rdata, 32'hFFFFFFAD);
    xfer(1'b0, 32'h11, 32'h0, 2'b00, 1'b0);
    chk("load_byte_unsigned", last_rdata, 32'h000000AD);
    xfer(1'b0, 32'h12, 32'h0, 2'b01, 1'b1);
    chk("load_half_signed", last_rdata, 32'hFFFFBEEF);
    xfer(1'b1, 32'h13, 32'h00000012, 2'b00, 1'b0);
    xfer(1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
    chk("byte_merge", last_rdata, 32'hDEADBE12);

    rdy_mode = 1;
    issue(1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
    repeat (WS + 1 + 4) @(posedge clk);
    @(negedge clk);
    chk("stall_rsp_valid", {31'h0, rsp_valid}, 32'd1);
    chk("stall_req_ready", {31'h0, req_ready}, 32'd0);
    chk("stall_rsp_rdata", rsp_rdata, 32'hDEADBE12);
    rdy_mode = 2;
    wait_done();
    @(negedge clk);
    chk("release_req_ready", {31'h0, req_ready}, 32'd1);
    rdy_mode = 0;

    xfer(1'b1, 32'h12, 32'h11223344, 2'b10, 1'b0);
    xfer(1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
`ifdef DMEM_ALIGN_CHECK_EN
    old_word = 32'hDEADBE12;
`else
    old_word = 32'h11223344;
`endif
    chk("misaligned_word_result", last_rdata, old_word);

    issue(1'b1, 32'h10, 32'hCAFEF00D, 2'b10, 1'b0, 1'b0);
    #1;
    reset = 1'b1;
    #1;
    chk("midwait_reset_req_ready", {31'h0, req_ready}, 32'd1);
    chk("midwait_reset_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    chk("midwait_reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("midwait_reset_rsp_err", {31'h0, rsp_err}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    xfer(1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
    chk("store_dropped_by_reset", last_rdata, old_word);

    xfer(1'b1, 32'(NB + 'h10), 32'h5A5AA5A5, 2'b10, 1'b0);
    xfer(1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
    chk("alias_store", last_rdata, 32'h5A5AA5A5);
    xfer(1'b0, 32'(3 * NB + 'h12), 32'h0, 2'b01, 1'b0);
    chk("alias_load_half", last_rdata, 32'h0000A5A5);

    for (int i = 0; i < 300; i++) begin
      xfer(1'($urandom_range(0, 2) == 0), 32'($urandom_range(0, 2 * NB - 1)), $urandom,
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
